// File: rtl/riscv_imm_pkg.sv
// Shared RV32I/RV64I opcode constants and the immediate-format code used by the decode path.
package riscv_imm_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5,
      FMT_X = 3'd7
   } fmt_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and format classification for one 32-bit instruction.
module imm_extract
   import riscv_imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   logic [31:0] imm32;
   fmt_t        fmt_d;

   always_comb begin
      imm32   = '0;
      fmt_d   = FMT_R;
      illegal = 1'b0;
      unique case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
            imm32 = {{20{instr[31]}}, instr[31:20]};
            fmt_d = FMT_I;
         end
         OPC_STORE: begin
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            fmt_d = FMT_S;
         end
         OPC_BRANCH: begin
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            fmt_d = FMT_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm32 = {instr[31:12], 12'b0};
            fmt_d = FMT_U;
         end
         OPC_JAL: begin
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            fmt_d = FMT_J;
         end
         OPC_OP: begin
            fmt_d = FMT_R;
         end
         default: begin
            fmt_d   = FMT_X;
            illegal = 1'b1;
         end
      endcase
   end

   // All formats are already sign-extended to 32 bits; widen from bit 31 for RV64.
   assign imm = XLEN'($signed(imm32));
   assign fmt = fmt_d;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode into an output register, with a one-entry
// skid register so in_ready depends only on local state.
module imm_gen_stage
   import riscv_imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   logic            skid_valid;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] skid_pc;

   logic [31:0]     sel_instr;
   logic [XLEN-1:0] sel_pc;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;

   // The skid holds raw instr/pc only; one extractor decodes whichever source loads the output.
   assign sel_instr = skid_valid ? skid_instr : in_instr;
   assign sel_pc    = skid_valid ? skid_pc    : in_pc;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (sel_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   assign in_ready   = !skid_valid;
   assign out_target = out_pc + out_imm;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         out_valid   <= 1'b0;
         skid_valid  <= 1'b0;
         skid_instr  <= '0;
         skid_pc     <= '0;
         out_instr   <= '0;
         out_pc      <= '0;
         out_imm     <= '0;
         out_fmt     <= FMT_R;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
         // Output register is free or draining this cycle.
         if (skid_valid || in_valid) begin
            out_valid   <= 1'b1;
            skid_valid  <= 1'b0;
            out_instr   <= sel_instr;
            out_pc      <= sel_pc;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_illegal;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_valid && !skid_valid) begin
         skid_valid <= 1'b1;
         skid_instr <= in_instr;
         skid_pc    <= in_pc;
      end
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode vectors, stall/skid ordering, flush and reset,
// with a second instance at XLEN=64 for sign extension and target wrap.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [63:0] in_pc64;

   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_instr, out_pc, out_imm, out_target;
   logic [2:0]  out_fmt;

   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] out_instr64;
   logic [63:0] out_pc64, out_imm64, out_target64;
   logic [2:0]  out_fmt64;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32)) dut (
      .clk (clk), .n_rst (n_rst), .flush (flush),
      .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr), .in_pc (in_pc),
      .out_valid (out_valid), .out_ready (out_ready), .out_instr (out_instr), .out_pc (out_pc),
      .out_imm (out_imm), .out_target (out_target), .out_fmt (out_fmt), .out_illegal (out_illegal)
   );

   imm_gen_stage #(.XLEN(64)) dut64 (
      .clk (clk), .n_rst (n_rst), .flush (flush),
      .in_valid (in_valid), .in_ready (in_ready64), .in_instr (in_instr), .in_pc (in_pc64),
      .out_valid (out_valid64), .out_ready (out_ready), .out_instr (out_instr64), .out_pc (out_pc64),
      .out_imm (out_imm64), .out_target (out_target64), .out_fmt (out_fmt64), .out_illegal (out_illegal64)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = 32'h0; in_pc = 32'h0; in_pc64 = 64'h0;
      tick(); tick();
      check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
      check("rst_in_ready",   {63'd0, in_ready}, 64'd1);
      check("rst_out_instr",  {32'd0, out_instr}, 64'd0);
      check("rst_out_imm",    {32'd0, out_imm}, 64'd0);
      check("rst_out_target", {32'd0, out_target}, 64'd0);
      check("rst_out_fmt",    {61'd0, out_fmt}, 64'd0);
      check("rst_illegal",    {63'd0, out_illegal}, 64'd0);
      n_rst = 1'b1;

      // addi x1,x0,-1
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h0; in_pc64 = 64'h0;
      tick();
      check("addi_valid",   {63'd0, out_valid}, 64'd1);
      check("addi_instr",   {32'd0, out_instr}, 64'hFFF00093);
      check("addi_imm",     {32'd0, out_imm}, 64'hFFFFFFFF);
      check("addi_fmt",     {61'd0, out_fmt}, 64'd1);
      check("addi_illegal", {63'd0, out_illegal}, 64'd0);
      check("addi_imm64",   out_imm64, 64'hFFFFFFFFFFFFFFFF);

      // beq x0,x0,-4
      in_instr = 32'hFE000EE3; in_pc = 32'h100; in_pc64 = 64'h100;
      tick();
      check("beq_imm",    {32'd0, out_imm}, 64'hFFFFFFFC);
      check("beq_target", {32'd0, out_target}, 64'h000000FC);
      check("beq_fmt",    {61'd0, out_fmt}, 64'd3);

      // lui x5,0x12345
      in_instr = 32'h123452B7; in_pc = 32'h200;
      tick();
      check("lui_imm", {32'd0, out_imm}, 64'h12345000);
      check("lui_fmt", {61'd0, out_fmt}, 64'd4);
      check("lui_pc",  {32'd0, out_pc}, 64'h200);

      // unknown opcode
      in_instr = 32'h0000007F;
      tick();
      check("ill_flag", {63'd0, out_illegal}, 64'd1);
      check("ill_imm",  {32'd0, out_imm}, 64'd0);
      check("ill_fmt",  {61'd0, out_fmt}, 64'd7);

      // jal +4; 64-bit pc wraps
      in_instr = 32'h0040006F; in_pc = 32'h300; in_pc64 = 64'hFFFFFFFFFFFFFFFE;
      tick();
      check("jal_imm",      {32'd0, out_imm}, 64'h4);
      check("jal_target",   {32'd0, out_target}, 64'h304);
      check("jal_fmt",      {61'd0, out_fmt}, 64'd5);
      check("jal_target64", out_target64, 64'h2);

      // sw x5,-8(x2)
      in_instr = 32'hFE512C23; in_pc = 32'h310; in_pc64 = 64'h0;
      tick();
      check("sw_imm", {32'd0, out_imm}, 64'hFFFFFFF8);
      check("sw_fmt", {61'd0, out_fmt}, 64'd2);

      // add x10,x10,x11
      in_instr = 32'h00B50533;
      tick();
      check("add_imm",     {32'd0, out_imm}, 64'd0);
      check("add_fmt",     {61'd0, out_fmt}, 64'd0);
      check("add_illegal", {63'd0, out_illegal}, 64'd0);

      in_valid = 1'b0;
      tick();
      check("drain_valid", {63'd0, out_valid}, 64'd0);

      // Stall: A held, B to skid, C stalled
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
      tick();
      check("stall_A_out", {32'd0, out_instr}, 64'h00100093);
      in_instr = 32'h00200113; in_pc = 32'h404;
      tick();
      check("stall_A_held",  {32'd0, out_instr}, 64'h00100093);
      check("stall_B_ready", {63'd0, in_ready}, 64'd0);
      in_instr = 32'h00300193; in_pc = 32'h408;
      tick();
      check("stall_A_still", {32'd0, out_instr}, 64'h00100093);
      check("stall_A_imm",   {32'd0, out_imm}, 64'h1);
      check("stall_A_pc",    {32'd0, out_pc}, 64'h400);
      check("stall_C_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      tick();
      check("drain_B",       {32'd0, out_instr}, 64'h00200113);
      check("drain_B_imm",   {32'd0, out_imm}, 64'h2);
      check("drain_B_ready", {63'd0, in_ready}, 64'd1);
      tick();
      check("drain_C",       {32'd0, out_instr}, 64'h00300193);
      check("drain_C_valid", {63'd0, out_valid}, 64'd1);
      check("drain_C_pc",    {32'd0, out_pc}, 64'h408);
      in_valid = 1'b0;
      tick();
      check("drain_done", {63'd0, out_valid}, 64'd0);

      // Flush with output and skid full, D presented
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 32'h500;
      tick();
      in_instr = 32'h00600313; in_pc = 32'h504;
      tick();
      check("full_ready", {63'd0, in_ready}, 64'd0);
      in_instr = 32'h00700393; in_pc = 32'h508; flush = 1'b1;
      tick();
      check("flush_valid", {63'd0, out_valid}, 64'd0);
      check("flush_ready", {63'd0, in_ready}, 64'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("flush_no_D", {63'd0, out_valid}, 64'd0);

      // Flush discards an entry even with in_ready=1
      in_valid = 1'b1; in_instr = 32'h00800413; flush = 1'b1;
      tick();
      check("flush_empty_drop", {63'd0, out_valid}, 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      check("flush_empty_after", {63'd0, out_valid}, 64'd0);

      // Reset mid-stall
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00900493; in_pc = 32'h600;
      tick();
      in_instr = 32'h00A00513; in_pc = 32'h604;
      tick();
      check("prerst_ready", {63'd0, in_ready}, 64'd0);
      n_rst = 1'b0;
      tick();
      check("midrst_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_ready", {63'd0, in_ready}, 64'd1);
      check("midrst_instr", {32'd0, out_instr}, 64'd0);
      n_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("postrst_valid", {63'd0, out_valid}, 64'd0);

      // Recovery after reset
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h10;
      tick();
      check("recover_valid",  {63'd0, out_valid}, 64'd1);
      check("recover_target", {32'd0, out_target}, 64'hF);
      in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
